// File: rtl/move_controller.sv
// Sequences one 2048 move over a 4x4 register-file board: button arbitration, lane-serial
// compress/merge/compress, spawn scan from a random index, and the game-over evaluation.
module move_controller #(
  parameter int TILE_W    = 16,
  parameter int SPAWN_VAL = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  btn_l,
  input  logic                  btn_r,
  input  logic                  btn_u,
  input  logic                  btn_d,
  input  logic [3:0]            rand_idx,
  output logic [0:16*TILE_W-1]  board_out,
  output logic                  busy,
  output logic                  move_done,
  output logic                  moved,
  output logic [16:0]           score_add,
  output logic                  game_over
);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_MOVE, S_SPAWN, S_CHECK, S_OVER} state_e;
  typedef enum logic [1:0] {DIR_L, DIR_R, DIR_U, DIR_D} dir_e;

  localparam logic [TILE_W-1:0] SAT_TILE   = {1'b1, {(TILE_W-1){1'b0}}};
  localparam logic [TILE_W-1:0] SPAWN_TILE = TILE_W'(SPAWN_VAL);

  state_e            state_q, state_d;
  dir_e              dir_q, dir_d;
  logic [1:0]        lane_q, lane_d;
  logic [3:0]        ptr_q, ptr_d;
  logic [3:0]        scan_q, scan_d;
  logic              changed_q, changed_d;
  logic [16:0]       score_q, score_d;
  logic [3:0]        btn_hist_q, btn_hist_d;
  logic [TILE_W-1:0] cell_q [16];
  logic [TILE_W-1:0] cell_d [16];
  logic              move_done_q, move_done_d;
  logic              moved_q, moved_d;
  logic [16:0]       score_add_q, score_add_d;
  logic              game_over_q, game_over_d;
  logic              busy_q, busy_d;

  logic [3:0]        btn_now, rise;
  logic [TILE_W-1:0] lane_in [4];
  logic [TILE_W-1:0] c1 [4];
  logic [TILE_W-1:0] mg [4];
  logic [TILE_W-1:0] lane_out [4];
  logic [16:0]       lane_add;
  logic              lane_changed;
  logic              board_over;
  logic [2:0]        wr;

  // Element 0 of every lane sits at the edge the tiles slide toward.
  function automatic logic [3:0] lane_idx(input dir_e dir, input logic [1:0] lane,
                                          input logic [1:0] e);
    case (dir)
      DIR_L:   lane_idx = {lane, e};
      DIR_R:   lane_idx = {lane, 2'd3 - e};
      DIR_U:   lane_idx = {e, lane};
      default: lane_idx = {2'd3 - e, lane};
    endcase
  endfunction

  function automatic logic can_merge(input logic [TILE_W-1:0] a, input logic [TILE_W-1:0] b);
    can_merge = (a != '0) && (a == b) && (a != SAT_TILE);
  endfunction

  assign btn_now = {btn_u, btn_d, btn_l, btn_r};
  assign rise    = btn_now & ~btn_hist_q;

  always_comb begin
    lane_add     = '0;
    lane_changed = 1'b0;
    wr           = '0;
    for (int e = 0; e < 4; e++) begin
      lane_in[e]  = cell_q[lane_idx(dir_q, lane_q, 2'(e))];
      c1[e]       = '0;
      lane_out[e] = '0;
    end
    for (int e = 0; e < 4; e++) begin
      if (lane_in[e] != '0) begin
        c1[wr[1:0]] = lane_in[e];
        wr          = wr + 3'd1;
      end
    end
    // A merged slot is zeroed so its partner can never merge a second time.
    mg = c1;
    for (int e = 0; e < 3; e++) begin
      if (can_merge(mg[e], mg[e+1])) begin
        mg[e]    = mg[e] << 1;
        mg[e+1]  = '0;
        lane_add = lane_add + 17'(mg[e]);
      end
    end
    wr = '0;
    for (int e = 0; e < 4; e++) begin
      if (mg[e] != '0) begin
        lane_out[wr[1:0]] = mg[e];
        wr                = wr + 3'd1;
      end
    end
    for (int e = 0; e < 4; e++) begin
      if (lane_out[e] != lane_in[e]) lane_changed = 1'b1;
    end
  end

  always_comb begin
    board_over = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (cell_q[i] == '0) board_over = 1'b0;
      if ((i % 4) != 3 && can_merge(cell_q[i], cell_q[i+1])) board_over = 1'b0;
      if (i < 12 && can_merge(cell_q[i], cell_q[i+4])) board_over = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    lane_d      = lane_q;
    ptr_d       = ptr_q;
    scan_d      = scan_q;
    changed_d   = changed_q;
    score_d     = score_q;
    btn_hist_d  = btn_now;
    cell_d      = cell_q;
    move_done_d = 1'b0;
    moved_d     = moved_q;
    score_add_d = score_add_q;
    game_over_d = game_over_q;
    case (state_q)
      S_INIT: begin
        cell_d[rand_idx] = SPAWN_TILE;
        state_d          = S_IDLE;
      end
      S_IDLE: begin
        if (rise != 4'b0000) begin
          if (rise[3])      dir_d = DIR_U;
          else if (rise[2]) dir_d = DIR_D;
          else if (rise[1]) dir_d = DIR_L;
          else              dir_d = DIR_R;
          changed_d = 1'b0;
          score_d   = '0;
          lane_d    = '0;
          state_d   = S_MOVE;
        end
      end
      S_MOVE: begin
        for (int e = 0; e < 4; e++) cell_d[lane_idx(dir_q, lane_q, 2'(e))] = lane_out[e];
        changed_d = changed_q | lane_changed;
        score_d   = score_q + lane_add;
        lane_d    = lane_q + 2'd1;
        if (lane_q == 2'd3) begin
          if (changed_q | lane_changed) begin
            ptr_d   = rand_idx;
            scan_d  = '0;
            state_d = S_SPAWN;
          end else begin
            state_d = S_CHECK;
          end
        end
      end
      S_SPAWN: begin
        if (cell_q[ptr_q] == '0) begin
          cell_d[ptr_q] = SPAWN_TILE;
          state_d       = S_CHECK;
        end else if (scan_q == 4'd15) begin
          state_d = S_CHECK;
        end else begin
          ptr_d  = ptr_q + 4'd1;
          scan_d = scan_q + 4'd1;
        end
      end
      S_CHECK: begin
        move_done_d = 1'b1;
        moved_d     = changed_q;
        score_add_d = score_q;
        if (board_over) begin
          game_over_d = 1'b1;
          state_d     = S_OVER;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: ;
    endcase
    busy_d = (state_d != S_IDLE) && (state_d != S_OVER);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_INIT;
      dir_q       <= DIR_L;
      lane_q      <= '0;
      ptr_q       <= '0;
      scan_q      <= '0;
      changed_q   <= 1'b0;
      score_q     <= '0;
      btn_hist_q  <= btn_now;
      for (int i = 0; i < 16; i++) cell_q[i] <= '0;
      move_done_q <= 1'b0;
      moved_q     <= 1'b0;
      score_add_q <= '0;
      game_over_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      lane_q      <= lane_d;
      ptr_q       <= ptr_d;
      scan_q      <= scan_d;
      changed_q   <= changed_d;
      score_q     <= score_d;
      btn_hist_q  <= btn_hist_d;
      cell_q      <= cell_d;
      move_done_q <= move_done_d;
      moved_q     <= moved_d;
      score_add_q <= score_add_d;
      game_over_q <= game_over_d;
      busy_q      <= busy_d;
    end
  end

  for (genvar i = 0; i < 16; i++) begin : g_board
    assign board_out[i*TILE_W +: TILE_W] = cell_q[i];
  end

  assign busy      = busy_q;
  assign move_done = move_done_q;
  assign moved     = moved_q;
  assign score_add = score_add_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_move_controller.sv
// Self-checking bench for move_controller: a reference 2048 model predicts each move and
// the expected record is queued at press time and popped when move_done pulses.
module tb_move_controller;

  localparam logic [3:0] M_U = 4'b1000;
  localparam logic [3:0] M_D = 4'b0100;
  localparam logic [3:0] M_L = 4'b0010;
  localparam logic [3:0] M_R = 4'b0001;

  typedef struct packed {
    logic         moved;
    logic [16:0]  score;
    logic [7:0]   lat;
    logic         over;
    logic [255:0] board;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          btn_l, btn_r, btn_u, btn_d;
  logic [3:0]    rand_idx;
  logic [0:255]  board_out;
  logic          busy, move_done, moved, game_over;
  logic [16:0]   score_add;

  logic [15:0]   mdl [16];
  exp_t          exp_q [$];
  int            n_checks;
  int            n_fail;

  move_controller #(.TILE_W(16), .SPAWN_VAL(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_l     (btn_l),
    .btn_r     (btn_r),
    .btn_u     (btn_u),
    .btn_d     (btn_d),
    .rand_idx  (rand_idx),
    .board_out (board_out),
    .busy      (busy),
    .move_done (move_done),
    .moved     (moved),
    .score_add (score_add),
    .game_over (game_over)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model
  function automatic logic [255:0] mdl_bus();
    logic [0:255] b;
    for (int i = 0; i < 16; i++) b[i*16 +: 16] = mdl[i];
    return b;
  endfunction

  function automatic bit mdl_over();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (mdl[r*4+c] == 16'd0) return 1'b0;
        if (c < 3 && mdl[r*4+c] == mdl[r*4+c+1] && mdl[r*4+c] != 16'h8000) return 1'b0;
        if (r < 3 && mdl[r*4+c] == mdl[r*4+c+4] && mdl[r*4+c] != 16'h8000) return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  function automatic void mdl_apply(input logic [3:0] mask, output bit ch, output logic [16:0] sc);
    ch = 1'b0;
    sc = '0;
    for (int k = 0; k < 4; k++) begin
      int          idx [4];
      logic [15:0] lst [$];
      logic [15:0] o [4];
      int          n;
      int          i;
      for (int e = 0; e < 4; e++) begin
        if (mask[3])      idx[e] = e*4 + k;
        else if (mask[2]) idx[e] = (3-e)*4 + k;
        else if (mask[1]) idx[e] = k*4 + e;
        else              idx[e] = k*4 + 3 - e;
        o[e] = 16'd0;
      end
      lst.delete();
      for (int e = 0; e < 4; e++) if (mdl[idx[e]] != 16'd0) lst.push_back(mdl[idx[e]]);
      n = 0;
      i = 0;
      while (i < lst.size()) begin
        if (i + 1 < lst.size() && lst[i] == lst[i+1] && lst[i] != 16'h8000) begin
          o[n] = lst[i] * 2;
          sc   = sc + 17'(o[n]);
          i    = i + 2;
        end else begin
          o[n] = lst[i];
          i    = i + 1;
        end
        n++;
      end
      for (int e = 0; e < 4; e++) begin
        if (o[e] != mdl[idx[e]]) ch = 1'b1;
        mdl[idx[e]] = o[e];
      end
    end
  endfunction

  // driver tasks
  task automatic do_reset(input logic [3:0] ridx, input logic [3:0] held);
    @(negedge clk);
    rst_n    = 1'b0;
    rand_idx = ridx;
    {btn_u, btn_d, btn_l, btn_r} = held;
    repeat (2) @(negedge clk);
    check("rst_zero_board", board_out, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", move_done, 1'b0);
    check("rst_score", score_add, '0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) mdl[i] = 16'd0;
    mdl[ridx] = 16'd2;
    exp_q.delete();
    check("init_board", board_out, mdl_bus());
    check("init_busy", busy, 1'b0);
    check("init_over", game_over, 1'b0);
  endtask

  task automatic do_move(input logic [3:0] mask, input logic [3:0] ridx, input bit poke_d);
    exp_t        e;
    bit          ch;
    logic [16:0] sc;
    int          p;
    int          k;
    bit          done;
    @(negedge clk);
    rand_idx = ridx;
    {btn_u, btn_d, btn_l, btn_r} = mask;
    mdl_apply(mask, ch, sc);
    e.lat = 8'd6;
    if (ch) begin
      p = ridx;
      k = 0;
      while (mdl[p] != 16'd0 && k < 16) begin
        p = (p + 1) % 16;
        k++;
      end
      if (k < 16) mdl[p] = 16'd2;
      e.lat = 8'(7 + k);
    end
    e.moved = ch;
    e.score = sc;
    e.over  = mdl_over();
    e.board = mdl_bus();
    exp_q.push_back(e);
    done = 1'b0;
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        {btn_u, btn_d, btn_l, btn_r} = 4'b0000;
        check("busy_in_move", busy, 1'b1);
      end
      if (poke_d && cyc == 2) btn_d = 1'b1;
      if (poke_d && cyc == 4) btn_d = 1'b0;
      if (move_done) begin
        e = exp_q.pop_front();
        check("moved", moved, e.moved);
        check("score_add", score_add, e.score);
        check("latency", cyc, e.lat);
        check("game_over", game_over, e.over);
        check("busy_at_done", busy, 1'b0);
        check("board", board_out, e.board);
        done = 1'b1;
      end
    end
    btn_d = 1'b0;
    if (!done) begin
      check("move_timeout", 1'b0, 1'b1);
      exp_q.delete();
    end
  endtask

  // stimulus and final report
  initial begin
    logic [3:0] mask;
    logic [255:0] frozen;
    int seen;
    int nmov;
    bit poke;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    {btn_u, btn_d, btn_l, btn_r} = 4'b0000;
    rand_idx = 4'd0;

    do_reset(4'd5, 4'b0000);

    // A button held through reset must not start a move.
    do_reset(4'd3, M_L);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (move_done) seen++;
    end
    check("held_no_move", seen, 0);
    check("held_board", board_out, mdl_bus());
    btn_l = 1'b0;
    @(negedge clk);

    do_move(M_R, 4'd0, 1'b0);
    do_move(M_R, 4'd1, 1'b0);
    do_move(M_L, 4'd0, 1'b0);
    do_move(M_U | M_L, 4'd2, 1'b1);
    do_move(M_D, 4'd6, 1'b0);
    do_move(M_L | M_R, 4'd15, 1'b0);
    do_move(M_D | M_R, 4'd9, 1'b1);
    do_move(M_U, 4'd12, 1'b0);

    nmov = 0;
    while (!mdl_over() && nmov < 1000) begin
      mask = 4'b0001 << $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) mask = mask | (4'b0001 << $urandom_range(0, 3));
      poke = ($urandom_range(0, 7) == 0) && !mask[2];
      do_move(mask, 4'($urandom_range(0, 15)), poke);
      nmov++;
    end

    check("end_game_over", game_over, mdl_over());
    if (mdl_over()) begin
      frozen = mdl_bus();
      check("over_busy", busy, 1'b0);
      seen = 0;
      for (int b = 0; b < 4; b++) begin
        @(negedge clk);
        {btn_u, btn_d, btn_l, btn_r} = 4'b0001 << b;
        @(negedge clk);
        if (move_done) seen++;
        {btn_u, btn_d, btn_l, btn_r} = 4'b0000;
      end
      repeat (10) begin
        @(negedge clk);
        if (move_done) seen++;
      end
      check("over_no_done", seen, 0);
      check("over_frozen", board_out, frozen);
      check("over_sticky", game_over, 1'b1);
    end

    do_reset(4'd9, 4'b0000);

    // Reset during the second MOVE cycle abandons the move.
    @(negedge clk);
    rand_idx = 4'd0;
    btn_l    = 1'b1;
    @(negedge clk);
    btn_l = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midmove_board", board_out, '0);
    check("midmove_done", move_done, 1'b0);
    check("midmove_busy", busy, 1'b0);
    rand_idx = 4'd7;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) mdl[i] = 16'd0;
    mdl[7] = 16'd2;
    check("midmove_init", board_out, mdl_bus());
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (move_done) seen++;
    end
    check("midmove_no_done", seen, 0);
    do_move(M_U, 4'd3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
